// File: rtl/uart_rx_os_pkg.sv
// uart_rx_os_pkg: shared definitions for the oversampling UART receiver.
//   - rx_state_e : receiver FSM state encodings (ST_PARITY exists only
//                  when UART_RX_PARITY_EN is defined)
//   - DATA_W     : serial data width (8)
//   - OSR_DEF    : default oversampling ratio
//   - calc_div() : clocks per oversampling tick, CLK_HZ/(BAUD*OSR) truncated
package uart_rx_os_pkg;

  localparam int DATA_W  = 8;
  localparam int OSR_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

  // Never returns less than 1 so a tiny CLK_HZ still yields a working divider.
  function automatic int calc_div(input int clk_hz, input int baud, input int osr);
    int div;
    div = clk_hz / (baud * osr);
    if (div < 1) div = 1;
    return div;
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: serial line plus parallel result bundle of the receiver.
//   rs232_rx   : serial line, idle high (line side -> receiver)
//   rx_data    : last received byte
//   rx_int     : high while a frame is being received
//   rx_done    : one-cycle pulse when a frame completes
//   frame_err  : one-cycle pulse with rx_done when the stop bit is low
//   parity_err : one-cycle pulse with rx_done on parity mismatch
//   dbg_state  : current receiver FSM state, for observation only
// Handshake: there is no back-pressure. rx_done is a single-cycle valid
// strobe; rx_data is valid from that cycle until the next rx_done, and the
// error pulses are only meaningful in the cycle rx_done is high.
// modport master: drives the line, observes results (bench / line model).
// modport slave : the receiver itself.
interface uart_rx_os_if;
  import uart_rx_os_pkg::*;

  logic              rs232_rx;
  logic [DATA_W-1:0] rx_data;
  logic              rx_int;
  logic              rx_done;
  logic              frame_err;
  logic              parity_err;
  rx_state_e         dbg_state;

  modport master (
    output rs232_rx,
    input  rx_data, rx_int, rx_done, frame_err, parity_err, dbg_state
  );

  modport slave (
    input  rs232_rx,
    output rx_data, rx_int, rx_done, frame_err, parity_err, dbg_state
  );
endinterface

// File: rtl/uart_rx_os_baud_tick.sv
// uart_baud_tick: free-running clock divider producing a one-cycle tick
// every DIV clocks. A synchronous clear restarts the count so the first
// tick after clear arrives DIV clocks later.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of the divider
//   tick       : one-cycle pulse every DIV clocks
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver, 8N1 by default, 8E1 when the
// UART_RX_PARITY_EN macro is defined. Each bit is decided by a majority
// vote of three samples around mid-bit; the vote is taken on the third
// sample tick ("midpoint").
//   clk, rst_n : clock, asynchronous active-low reset
//   rx_if      : uart_rx_os_if.slave (line in, byte/flags/debug state out)
// Parameters: CLK_HZ, BAUD, OSR (even, >= 8).
module uart_rx_os
  import uart_rx_os_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600,
  parameter int OSR    = OSR_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_os_if.slave  rx_if
);
  localparam int DIV = calc_div(CLK_HZ, BAUD, OSR);
  localparam int OW  = $clog2(OSR);

  logic              sync1_q, sync2_q, sync3_q;
  rx_state_e         state_q, state_d;
  logic [OW-1:0]     os_cnt_q, os_cnt_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              s0_q, s0_d, s1_q, s1_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_int_q, rx_int_d;
  logic              rx_done_q, rx_done_d;
  logic              frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d;
  logic              parity_err_q, parity_err_d;
`endif

  logic tick, fall, clr, vote, midpoint;

  // sync3 lags sync2 by one clock, so this is a synchronized 1->0 edge.
  assign fall     = sync3_q & ~sync2_q;
  assign clr      = (state_q == ST_IDLE) && fall;
  // Third sample is the live synchronized line on the midpoint tick.
  assign vote     = (s0_q & s1_q) | (s0_q & sync2_q) | (s1_q & sync2_q);
  assign midpoint = tick && (os_cnt_q == OW'(OSR/2 + 1));

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .tick  (tick)
  );

  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    rx_data_d   = rx_data_q;
    rx_int_d    = rx_int_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (clr) begin
      os_cnt_d = '0;
    end else if (tick) begin
      os_cnt_d = (os_cnt_q == OW'(OSR - 1)) ? '0 : os_cnt_q + 1'b1;
      if (os_cnt_q == OW'(OSR/2 - 1)) s0_d = sync2_q;
      if (os_cnt_q == OW'(OSR/2))     s1_d = sync2_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (fall) begin
          state_d   = ST_START;
          bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (midpoint) begin
          if (vote) begin
            state_d = ST_IDLE;          // false start: glitch, no output
          end else begin
            state_d   = ST_DATA;
            rx_int_d  = 1'b1;
            bit_cnt_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (midpoint) begin
          shift_d   = {vote, shift_q[DATA_W-1:1]};   // LSB first
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (midpoint) begin
          // Even parity: the parity bit must equal the XOR of the data bits.
          par_bad_d = vote ^ (^shift_q);
          state_d   = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (midpoint) begin
          // Leave at stop midpoint so a zero-gap next start edge is seen.
          rx_data_d   = shift_q;
          rx_int_d    = 1'b0;
          rx_done_d   = 1'b1;
          frame_err_d = ~vote;
`ifdef UART_RX_PARITY_EN
          parity_err_d = par_bad_q;
`endif
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync3_q     <= 1'b1;
      state_q     <= ST_IDLE;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      rx_data_q   <= '0;
      rx_int_q    <= 1'b0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync1_q     <= rx_if.rs232_rx;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      state_q     <= state_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      rx_data_q   <= rx_data_d;
      rx_int_q    <= rx_int_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_int    = rx_int_q;
  assign rx_if.rx_done   = rx_done_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.dbg_state = state_q;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = parity_err_q;
`else
  assign rx_if.parity_err = 1'b0;
`endif
endmodule
